axi_lite_sub: RTL and testbench
===============================

// Module: axi_lite_sub
// PURPOSE
//  AXI4-Lite subordinate exposing a bank of 32-bit read/write registers.
//  Sits behind an AXI4-Lite manager (CPU/interconnect or test VIP) and gives software-visible storage.
//  Word addressed. Independent read and write channels. One outstanding transaction per direction.
// PARAMETERS
//  ADDR_WIDTH  32  width of s_axi_awaddr/s_axi_araddr
//  DATA_WIDTH  32  register/data width (only 32 supported)
//  NUM_REGS    16  number of registers, power of 2; map 0x00..(NUM_REGS*4-4)
// PORTS
//  clk            in   1           single clock, all logic on rising edge
//  reset          in   1           synchronous, active-high reset
//  s_axi_awaddr   in   ADDR_WIDTH  write address
//  s_axi_awvalid  in   1           write address valid
//  s_axi_awready  out  1           write address ready
//  s_axi_wdata    in   DATA_WIDTH  write data (no strobes; full-word writes)
//  s_axi_wvalid   in   1           write data valid
//  s_axi_wready   out  1           write data ready
//  s_axi_bresp    out  2           write response (00 OKAY, 10 SLVERR)
//  s_axi_bvalid   out  1           write response valid
//  s_axi_bready   in   1           write response ready
//  s_axi_araddr   in   ADDR_WIDTH  read address
//  s_axi_arvalid  in   1           read address valid
//  s_axi_arready  out  1           read address ready
//  s_axi_rdata    out  DATA_WIDTH  read data
//  s_axi_rresp    out  2           read response (00 OKAY, 10 SLVERR)
//  s_axi_rvalid   out  1           read data valid
//  s_axi_rready   in   1           read data ready
// BEHAVIOUR
//  - Reset: all registers 0; awready/wready/arready/bvalid/rvalid 0 during reset; bresp/rresp/rdata 0.
//    Ready outputs go high the first cycle after reset deasserts.
//  - Reset mid-transaction: any latched address/data and pending B/R response are discarded; no register write.
//  - Register index = addr[2+:log2(NUM_REGS)]. addr[1:0] ignored.
//  - Write channel, states IDLE -> RESP:
//    IDLE: awready=1 until AW captured; wready=1 until W captured. Either order or same cycle.
//    The register is written on the edge where the second of AW/W handshakes; bvalid=1 from the next cycle.
//    RESP: awready=wready=0; bvalid and bresp held stable until bready=1, then return to IDLE.
//    Latency: bvalid 1 cycle after the last AW/W handshake. bready may be high in advance.
//  - Read channel, states IDLE -> DATA:
//    IDLE: arready=1. The AR handshake latches rdata/rresp; rvalid=1 next cycle.
//    DATA: arready=0; rdata/rresp held stable until rready=1, then return to IDLE.
//  - Read and write channels run concurrently. On a same-edge write commit and AR handshake to the same register,
//    the read returns the old (pre-write) value.
//  - Valid outputs never depend combinationally on input valids. No combinational path from inputs to outputs.
// CONFIGURATION
//  AXI_SUB_ADDR_CHECK_EN defined:
//    - An address >= NUM_REGS*4 returns SLVERR.
//    - Such a write is dropped. Such a read returns rdata=0.
//  Not defined:
//    - Upper address bits are ignored. The address aliases onto the register bank, always with OKAY.
// TESTING
//  1. After reset, read 0x00 -> rdata=0x00000000, rresp=OKAY.
//  2. Write 0x00=0xDEADBEEF -> bresp=OKAY; read 0x00 -> 0xDEADBEEF.
//  3. Read 0x20 -> 0; write 0x20=0xADADABAB; read 0x20 -> 0xADADABAB; read 0x00 still 0xDEADBEEF.
//  4. wvalid 3 cycles before awvalid, data 0x12345678 to 0x04:
//     bvalid exactly 1 cycle after the AW handshake; read 0x04 -> 0x12345678.
//  5. Hold rready/bready low 5 cycles: rvalid/bvalid and rdata/bresp stay stable; arready/awready stay 0.
//  6. With AXI_SUB_ADDR_CHECK_EN, write 0x40=0xFFFFFFFF -> SLVERR; read 0x40 -> SLVERR, rdata 0; read 0x00 unchanged.
//     Without the macro, read 0x40 -> OKAY, aliases to 0x00.

Source files
------------

// File: rtl/axi_lite_sub_if.sv
// AXI4-Lite bus bundle between a manager and the axi_lite_sub register bank.
// Parameters: ADDR_WIDTH (address width), DATA_WIDTH (data width).
// Modports: master drives AW/W/AR valid+payload and B/R ready;
//           slave drives AW/W/AR ready and B/R valid+payload.
interface axi_lite_sub_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [DATA_WIDTH-1:0] s_axi_wdata;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [DATA_WIDTH-1:0] s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
    output s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
    input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );
endinterface

// File: rtl/axi_lite_sub.sv
// AXI4-Lite subordinate: bank of NUM_REGS word-addressed 32-bit registers,
// one outstanding transaction per direction, read and write run concurrently.
// Ports: clk (rising edge), reset (synchronous, active high),
//        bus (axi_lite_sub_if.slave: AW, W, B, AR, R channels).
// Optional build macro AXI_SUB_ADDR_CHECK_EN: addresses >= NUM_REGS*4 answer
// SLVERR, writes to them are dropped and reads return 0. Without it the upper
// address bits are ignored and every address aliases onto the bank with OKAY.
// All outputs are registered.
module axi_lite_sub #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input logic           clk,
  input logic           reset,
  axi_lite_sub_if.slave bus
);

  localparam int unsigned IDX_W     = $clog2(NUM_REGS);
  localparam int unsigned MAP_BYTES = NUM_REGS * 4;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Half-captured write: whichever of AW/W arrived first is parked here.
  logic                  aw_got;
  logic                  w_got;
  logic [IDX_W-1:0]      aw_idx;
  logic                  aw_err;
  logic [DATA_WIDTH-1:0] w_data;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  aw_done;
  logic                  w_done;
  logic                  aw_bad;
  logic                  ar_bad;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_err;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [IDX_W-1:0]      ar_idx;

  assign aw_hs = bus.s_axi_awvalid & bus.s_axi_awready;
  assign w_hs  = bus.s_axi_wvalid & bus.s_axi_wready;
  assign ar_hs = bus.s_axi_arvalid & bus.s_axi_arready;

  assign aw_done = aw_got | aw_hs;
  assign w_done  = w_got | w_hs;

`ifdef AXI_SUB_ADDR_CHECK_EN
  assign aw_bad = (bus.s_axi_awaddr >= ADDR_WIDTH'(MAP_BYTES));
  assign ar_bad = (bus.s_axi_araddr >= ADDR_WIDTH'(MAP_BYTES));
`else
  assign aw_bad = 1'b0;
  assign ar_bad = 1'b0;
`endif

  // Commit uses the live channel if it handshakes this cycle, else the parked copy.
  assign wr_idx  = aw_hs ? bus.s_axi_awaddr[2 +: IDX_W] : aw_idx;
  assign wr_err  = aw_hs ? aw_bad : aw_err;
  assign wr_data = w_hs ? bus.s_axi_wdata : w_data;
  assign ar_idx  = bus.s_axi_araddr[2 +: IDX_W];

  // Write channel and register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state           <= W_IDLE;
      bus.s_axi_awready <= 1'b0;
      bus.s_axi_wready  <= 1'b0;
      bus.s_axi_bvalid  <= 1'b0;
      bus.s_axi_bresp   <= RESP_OKAY;
      aw_got            <= 1'b0;
      w_got             <= 1'b0;
      aw_idx            <= '0;
      aw_err            <= 1'b0;
      w_data            <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (w_state == W_IDLE) begin
      if (aw_done && w_done) begin
        if (!wr_err) regs[wr_idx] <= wr_data;
        bus.s_axi_bresp   <= wr_err ? RESP_SLVERR : RESP_OKAY;
        bus.s_axi_bvalid  <= 1'b1;
        bus.s_axi_awready <= 1'b0;
        bus.s_axi_wready  <= 1'b0;
        aw_got            <= 1'b0;
        w_got             <= 1'b0;
        w_state           <= W_RESP;
      end else begin
        if (aw_hs) begin
          aw_got <= 1'b1;
          aw_idx <= bus.s_axi_awaddr[2 +: IDX_W];
          aw_err <= aw_bad;
        end
        if (w_hs) begin
          w_got  <= 1'b1;
          w_data <= bus.s_axi_wdata;
        end
        // Also raises both readies on the first cycle out of reset.
        bus.s_axi_awready <= !aw_done;
        bus.s_axi_wready  <= !w_done;
      end
    end else begin
      if (bus.s_axi_bready) begin
        bus.s_axi_bvalid  <= 1'b0;
        bus.s_axi_awready <= 1'b1;
        bus.s_axi_wready  <= 1'b1;
        w_state           <= W_IDLE;
      end
    end
  end

  // Read channel; samples regs before any same-edge write lands (old value wins).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= R_IDLE;
      bus.s_axi_arready <= 1'b0;
      bus.s_axi_rvalid  <= 1'b0;
      bus.s_axi_rdata   <= '0;
      bus.s_axi_rresp   <= RESP_OKAY;
    end else if (r_state == R_IDLE) begin
      if (ar_hs) begin
        bus.s_axi_rdata   <= ar_bad ? '0 : regs[ar_idx];
        bus.s_axi_rresp   <= ar_bad ? RESP_SLVERR : RESP_OKAY;
        bus.s_axi_rvalid  <= 1'b1;
        bus.s_axi_arready <= 1'b0;
        r_state           <= R_DATA;
      end else begin
        bus.s_axi_arready <= 1'b1;
      end
    end else begin
      if (bus.s_axi_rready) begin
        bus.s_axi_rvalid  <= 1'b0;
        bus.s_axi_arready <= 1'b1;
        r_state           <= R_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sub.sv
// Self-checking bench for axi_lite_sub: directed scenarios followed by randomized
// reads/writes, checked against an array model of the register bank.
// Honours AXI_SUB_ADDR_CHECK_EN the same way the design does.
module tb_axi_lite_sub;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  axi_lite_sub_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_sub #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] model [16];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef AXI_SUB_ADDR_CHECK_EN
    return a >= 32'd64;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input int aw_start, input int w_start, input int hold,
                           input bit bready_early);
    bit aw_ok = 0;
    bit w_ok  = 0;
    int cyc   = 0;
    logic [1:0] exp_resp;
    exp_resp = addr_bad(addr) ? 2'b10 : 2'b00;
    bus.s_axi_bready = bready_early;
    while (!(aw_ok && w_ok) && cyc < 50) begin
      @(negedge clk);
      bus.s_axi_awaddr  = addr;
      bus.s_axi_wdata   = data;
      bus.s_axi_awvalid = !aw_ok && (cyc >= aw_start);
      bus.s_axi_wvalid  = !w_ok && (cyc >= w_start);
      check("bvalid_before_commit", 32'(bus.s_axi_bvalid), 32'd0);
      if (bus.s_axi_awvalid && bus.s_axi_awready) aw_ok = 1;
      if (bus.s_axi_wvalid && bus.s_axi_wready) w_ok = 1;
      cyc++;
    end
    if (!(aw_ok && w_ok)) begin
      check("write_handshake_timeout", 32'(aw_ok && w_ok), 32'd1);
      bus.s_axi_awvalid = 0;
      bus.s_axi_wvalid  = 0;
      bus.s_axi_bready  = 0;
      return;
    end
    @(negedge clk);
    bus.s_axi_awvalid = 0;
    bus.s_axi_wvalid  = 0;
    check("bvalid_latency", 32'(bus.s_axi_bvalid), 32'd1);
    check("bresp", 32'(bus.s_axi_bresp), 32'(exp_resp));
    if (!addr_bad(addr)) model[model_idx(addr)] = data;
    if (!bready_early) begin
      repeat (hold) begin
        @(negedge clk);
        check("bvalid_hold", 32'(bus.s_axi_bvalid), 32'd1);
        check("bresp_hold", 32'(bus.s_axi_bresp), 32'(exp_resp));
        check("awready_in_resp", 32'(bus.s_axi_awready), 32'd0);
        check("wready_in_resp", 32'(bus.s_axi_wready), 32'd0);
      end
      bus.s_axi_bready = 1;
    end
    @(negedge clk);
    bus.s_axi_bready = 0;
    check("bvalid_clear", 32'(bus.s_axi_bvalid), 32'd0);
    check("awready_after_b", 32'(bus.s_axi_awready), 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_start, input int hold,
                          input bit rready_early);
    bit ar_ok = 0;
    int cyc   = 0;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    exp_resp = addr_bad(addr) ? 2'b10 : 2'b00;
    exp_data = addr_bad(addr) ? 32'd0 : model[model_idx(addr)];
    bus.s_axi_rready = rready_early;
    while (!ar_ok && cyc < 50) begin
      @(negedge clk);
      bus.s_axi_araddr  = addr;
      bus.s_axi_arvalid = (cyc >= ar_start);
      check("rvalid_before_ar", 32'(bus.s_axi_rvalid), 32'd0);
      if (bus.s_axi_arvalid && bus.s_axi_arready) ar_ok = 1;
      cyc++;
    end
    if (!ar_ok) begin
      check("read_handshake_timeout", 32'(ar_ok), 32'd1);
      bus.s_axi_arvalid = 0;
      bus.s_axi_rready  = 0;
      return;
    end
    @(negedge clk);
    bus.s_axi_arvalid = 0;
    check("rvalid_latency", 32'(bus.s_axi_rvalid), 32'd1);
    check("rdata", bus.s_axi_rdata, exp_data);
    check("rresp", 32'(bus.s_axi_rresp), 32'(exp_resp));
    if (!rready_early) begin
      repeat (hold) begin
        @(negedge clk);
        check("rvalid_hold", 32'(bus.s_axi_rvalid), 32'd1);
        check("rdata_hold", bus.s_axi_rdata, exp_data);
        check("arready_in_data", 32'(bus.s_axi_arready), 32'd0);
      end
      bus.s_axi_rready = 1;
    end
    @(negedge clk);
    bus.s_axi_rready = 0;
    check("rvalid_clear", 32'(bus.s_axi_rvalid), 32'd0);
    check("arready_after_r", 32'(bus.s_axi_arready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] old_val;
    logic [31:0] a;
    logic [31:0] d;

    reset = 1;
    bus.s_axi_awaddr = 0; bus.s_axi_awvalid = 0; bus.s_axi_wdata = 0; bus.s_axi_wvalid = 0;
    bus.s_axi_bready = 0; bus.s_axi_araddr = 0; bus.s_axi_arvalid = 0; bus.s_axi_rready = 0;
    for (int i = 0; i < 16; i++) model[i] = 0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
    check("rst_wready", 32'(bus.s_axi_wready), 32'd0);
    check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
    check("rst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    check("rst_rdata", bus.s_axi_rdata, 32'd0);
    check("rst_bresp", 32'(bus.s_axi_bresp), 32'd0);
    check("rst_rresp", 32'(bus.s_axi_rresp), 32'd0);
    reset = 0;
    @(negedge clk);
    check("post_rst_awready", 32'(bus.s_axi_awready), 32'd1);
    check("post_rst_wready", 32'(bus.s_axi_wready), 32'd1);
    check("post_rst_arready", 32'(bus.s_axi_arready), 32'd1);

    // Directed scenarios.
    axi_read(32'h00, 0, 0, 0);
    check("read0_after_reset", model[0], 32'h0);
    axi_write(32'h00, 32'hDEADBEEF, 0, 0, 0, 0);
    axi_read(32'h00, 0, 0, 0);
    axi_read(32'h20, 0, 0, 1);
    axi_write(32'h20, 32'hADADABAB, 0, 0, 0, 1);
    axi_read(32'h20, 1, 0, 0);
    axi_read(32'h00, 0, 0, 0);
    axi_write(32'h04, 32'h12345678, 3, 0, 0, 0);
    axi_read(32'h04, 0, 0, 0);
    axi_write(32'h08, 32'h0BADF00D, 0, 2, 5, 0);
    axi_read(32'h08, 0, 5, 0);
    axi_write(32'h40, 32'hFFFFFFFF, 0, 0, 0, 0);
    axi_read(32'h40, 0, 0, 0);
    axi_read(32'h00, 0, 0, 0);
    axi_read(32'h7E, 0, 0, 0);

    // Same-edge write commit and read of one register returns the old value.
    @(negedge clk);
    old_val = model[3];
    bus.s_axi_awaddr = 32'h0C; bus.s_axi_wdata = 32'hCAFEF00D; bus.s_axi_araddr = 32'h0C;
    bus.s_axi_awvalid = 1; bus.s_axi_wvalid = 1; bus.s_axi_arvalid = 1;
    check("same_edge_ready", 32'(bus.s_axi_awready & bus.s_axi_wready & bus.s_axi_arready), 32'd1);
    @(negedge clk);
    bus.s_axi_awvalid = 0; bus.s_axi_wvalid = 0; bus.s_axi_arvalid = 0;
    check("same_edge_rdata_old", bus.s_axi_rdata, old_val);
    check("same_edge_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
    model[3] = 32'hCAFEF00D;
    bus.s_axi_bready = 1; bus.s_axi_rready = 1;
    @(negedge clk);
    bus.s_axi_bready = 0; bus.s_axi_rready = 0;
    check("same_edge_b_clear", 32'(bus.s_axi_bvalid), 32'd0);
    check("same_edge_r_clear", 32'(bus.s_axi_rvalid), 32'd0);
    axi_read(32'h0C, 0, 0, 0);

    // Reset mid-transaction: parked AW and pending R are discarded.
    @(negedge clk);
    bus.s_axi_awaddr = 32'h14; bus.s_axi_awvalid = 1;
    bus.s_axi_araddr = 32'h0C; bus.s_axi_arvalid = 1;
    @(negedge clk);
    bus.s_axi_awvalid = 0; bus.s_axi_arvalid = 0;
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 16; i++) model[i] = 0;
    check("midrst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    check("midrst_rdata", bus.s_axi_rdata, 32'd0);
    check("midrst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
    @(negedge clk);
    axi_write(32'h18, 32'h55AA55AA, 4, 0, 0, 0);
    axi_read(32'h14, 0, 0, 0);
    axi_read(32'h0C, 0, 0, 0);
    axi_read(32'h18, 0, 0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 80; n++) begin
      a = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      d = $urandom;
      if ($urandom_range(0, 1) == 1)
        axi_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      else
        axi_read(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 16; i++) axi_read(32'(i * 4), 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
